// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_fifo_ctrl
// Description : Single-clock FIFO controller for a negedge-clocked dual-port
//               RAM (port A write, port B read) with count and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int AFULL_THRESH = 2**ADDR_WIDTH - 2
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iWrEn,
  input  logic [DATA_WIDTH-1:0] iWrData,
  input  logic                  iRdEn,
  input  logic                  iFlush,
  output logic [DATA_WIDTH-1:0] oRdData,
  output logic                  oRdValid,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oAlmostFull,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oOverflow,
  output logic                  oUnderflow,
  output logic [ADDR_WIDTH-1:0] oRamAddrA,
  output logic [DATA_WIDTH-1:0] oRamDataA,
  output logic                  oRamEnA,
  output logic                  oRamWeA,
  output logic [ADDR_WIDTH-1:0] oRamAddrB,
  output logic                  oRamEnB,
  output logic                  oRamWeB,
  input  logic [DATA_WIDTH-1:0] iRamDataB
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  wr_acc, rd_acc;

  // Accept decisions look only at registered flags, so no bypass path exists.
  assign wr_acc = iWrEn & ~full_q  & ~iFlush;
  assign rd_acc = iRdEn & ~empty_q & ~iFlush;

  assign oRamEnA   = wr_acc & iRst_n;
  assign oRamWeA   = wr_acc & iRst_n;
  assign oRamAddrA = wr_ptr_q;
  assign oRamDataA = iWrData;
  assign oRamEnB   = rd_acc & iRst_n;
  assign oRamAddrB = rd_ptr_q;
  assign oRamWeB   = 1'b0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (iFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + PTR_ONE;
        rd_valid_d = 1'b1;
        rd_data_d  = iRamDataB;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (iWrEn & full_q)  ovf_d = 1'b1;
      if (iRdEn & empty_q) unf_d = 1'b1;
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    afull_d = (count_d >= AFULL_C);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign oRdData     = rd_data_q;
  assign oRdValid    = rd_valid_q;
  assign oFull       = full_q;
  assign oEmpty      = empty_q;
  assign oAlmostFull = afull_q;
  assign oCount      = count_q;
  assign oOverflow   = ovf_q;
  assign oUnderflow  = unf_q;

endmodule
`default_nettype wire
